// File: rtl/gobou_ctrl_net_pkg.sv
// Shared gobou definitions: word/address widths and controller state encoding.
package gobou_ctrl_net_pkg;

  localparam int unsigned DWIDTH  = 16;
  localparam int unsigned NETSIZE = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/gobou_ctrl_net_addr.sv
// Layer address generator: walks word-in-neuron and neuron counters and
// produces the next memory address plus bias/last flags for that address.
// Ports:
//   clk, rst               clock, async active-high reset
//   load_i                 latch cfg_* and restart the walk at cfg_base_i
//   issue_i                current next_addr_o was issued; advance
//   cfg_base_i/in_i/out_i  layer configuration
//   next_addr_o            address to issue next
//   bias_c_o, last_c_o     flags of next_addr_o (combinational)
module gobou_ctrl_net_addr
  import gobou_ctrl_net_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               issue_i,
  input  logic [NETSIZE-1:0] cfg_base_i,
  input  logic [NETSIZE-1:0] cfg_in_i,
  input  logic [NETSIZE-1:0] cfg_out_i,
  output logic [NETSIZE-1:0] next_addr_o,
  output logic               bias_c_o,
  output logic               last_c_o
);

  logic [NETSIZE-1:0] next_addr_q, next_addr_d;
  logic [NETSIZE-1:0] word_q, word_d;
  logic [NETSIZE-1:0] neuron_q, neuron_d;
  logic [NETSIZE-1:0] cfg_in_q, cfg_in_d;
  logic [NETSIZE-1:0] cfg_out_q, cfg_out_d;

  // Word index cfg_in is the bias slot; last neuron's bias ends the layer.
  assign bias_c_o = (word_q == cfg_in_q);
  assign last_c_o = bias_c_o && (neuron_q == (cfg_out_q - NETSIZE'(1)));

  // Counter advance; address wraps modulo 2^NETSIZE.
  always_comb begin
    next_addr_d = next_addr_q;
    word_d      = word_q;
    neuron_d    = neuron_q;
    cfg_in_d    = cfg_in_q;
    cfg_out_d   = cfg_out_q;
    if (load_i) begin
      next_addr_d = cfg_base_i;
      word_d      = '0;
      neuron_d    = '0;
      cfg_in_d    = cfg_in_i;
      cfg_out_d   = cfg_out_i;
    end else if (issue_i) begin
      next_addr_d = next_addr_q + NETSIZE'(1);
      if (bias_c_o) begin
        word_d   = '0;
        neuron_d = neuron_q + NETSIZE'(1);
      end else begin
        word_d   = word_q + NETSIZE'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_addr_q <= '0;
      word_q      <= '0;
      neuron_q    <= '0;
      cfg_in_q    <= '0;
      cfg_out_q   <= '0;
    end else begin
      next_addr_q <= next_addr_d;
      word_q      <= word_d;
      neuron_q    <= neuron_d;
      cfg_in_q    <= cfg_in_d;
      cfg_out_q   <= cfg_out_d;
    end
  end

  assign next_addr_o = next_addr_q;

endmodule

// File: rtl/gobou_ctrl_net.sv
// gobou network-weight memory sequencer/arbiter. In IDLE/DONE the host write
// port passes through to memory; on start one fully-connected layer is
// streamed to the datapath under valid/ready.
// Ports:
//   clk, rst                       clock, async active-high reset
//   start, cfg_base/in/out         layer request (sampled in IDLE)
//   busy, done                     RUN/DRAIN indicator, end-of-layer pulse
//   host_we/addr/wdata, host_ready host write port
//   mem_we, mem_addr, write_data   memory request (1-cycle read latency)
//   read_data                      memory read data
//   dp_valid/ready/data/bias/last  datapath beat stream
module gobou_ctrl_net
  import gobou_ctrl_net_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NETSIZE-1:0] cfg_base,
  input  logic [NETSIZE-1:0] cfg_in,
  input  logic [NETSIZE-1:0] cfg_out,
  output logic               busy,
  output logic               done,
  input  logic               host_we,
  input  logic [NETSIZE-1:0] host_addr,
  input  logic [DWIDTH-1:0]  host_wdata,
  output logic               host_ready,
  output logic               mem_we,
  output logic [NETSIZE-1:0] mem_addr,
  output logic [DWIDTH-1:0]  write_data,
  input  logic [DWIDTH-1:0]  read_data,
  output logic               dp_valid,
  input  logic               dp_ready,
  output logic [DWIDTH-1:0]  dp_data,
  output logic               dp_bias,
  output logic               dp_last
);

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               host_ready_q, host_ready_d;
  logic               dp_valid_q, dp_valid_d;
  logic               dp_bias_q, dp_bias_d;
  logic               dp_last_q, dp_last_d;
  logic [NETSIZE-1:0] beat_addr_q, beat_addr_d;

  logic               stall_c, xfer_c, issue_c, load_c;
  logic [NETSIZE-1:0] next_addr_c;
  logic               bias_c, last_c;

  assign stall_c = dp_valid_q & ~dp_ready;
  assign xfer_c  = dp_valid_q & dp_ready;
  assign issue_c = (state_q == ST_RUN) & ~stall_c;
  assign load_c  = (state_q == ST_IDLE) & start & (cfg_out != '0);

  gobou_ctrl_net_addr u_addr (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load_c),
    .issue_i     (issue_c),
    .cfg_base_i  (cfg_base),
    .cfg_in_i    (cfg_in),
    .cfg_out_i   (cfg_out),
    .next_addr_o (next_addr_c),
    .bias_c_o    (bias_c),
    .last_c_o    (last_c)
  );

  // Next state, registered status flags and beat register.
  always_comb begin
    state_d      = state_q;
    beat_addr_d  = beat_addr_q;
    dp_bias_d    = dp_bias_q;
    dp_last_d    = dp_last_q;
    dp_valid_d   = dp_valid_q;

    unique case (state_q)
      ST_IDLE:  if (start) state_d = (cfg_out == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (issue_c && last_c) state_d = ST_DRAIN;
      ST_DRAIN: if (xfer_c && dp_last_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // An unstalled RUN cycle always issues, so a transfer either coincides
    // with the next issue or retires the final beat.
    if (issue_c) begin
      beat_addr_d = next_addr_c;
      dp_bias_d   = bias_c;
      dp_last_d   = last_c;
      dp_valid_d  = 1'b1;
    end else if (xfer_c) begin
      dp_valid_d  = 1'b0;
    end

    busy_d       = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d       = (state_d == ST_DONE);
    host_ready_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      host_ready_q <= 1'b1;
      dp_valid_q   <= 1'b0;
      dp_bias_q    <= 1'b0;
      dp_last_q    <= 1'b0;
      beat_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      host_ready_q <= host_ready_d;
      dp_valid_q   <= dp_valid_d;
      dp_bias_q    <= dp_bias_d;
      dp_last_q    <= dp_last_d;
      beat_addr_q  <= beat_addr_d;
    end
  end

  // Re-presenting the stalled beat's address keeps read_data stable.
  assign mem_we     = host_we & host_ready_q;
  assign mem_addr   = host_ready_q ? host_addr :
                      (stall_c ? beat_addr_q : next_addr_c);
  assign write_data = host_wdata;

  assign busy       = busy_q;
  assign done       = done_q;
  assign host_ready = host_ready_q;
  assign dp_valid   = dp_valid_q;
  assign dp_bias    = dp_bias_q;
  assign dp_last    = dp_last_q;
  assign dp_data    = read_data;

endmodule

// File: tb/tb_gobou_ctrl_net.sv
module tb_gobou_ctrl_net;
  import gobou_ctrl_net_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [NETSIZE-1:0] cfg_base, cfg_in, cfg_out;
  logic               busy, done;
  logic               host_we;
  logic [NETSIZE-1:0] host_addr;
  logic [DWIDTH-1:0]  host_wdata;
  logic               host_ready;
  logic               mem_we;
  logic [NETSIZE-1:0] mem_addr;
  logic [DWIDTH-1:0]  write_data, read_data;
  logic               dp_valid, dp_ready;
  logic [DWIDTH-1:0]  dp_data;
  logic               dp_bias, dp_last;

  always #5 clk = ~clk;

  gobou_ctrl_net dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_base   (cfg_base),
    .cfg_in     (cfg_in),
    .cfg_out    (cfg_out),
    .busy       (busy),
    .done       (done),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ready (host_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .read_data  (read_data),
    .dp_valid   (dp_valid),
    .dp_ready   (dp_ready),
    .dp_data    (dp_data),
    .dp_bias    (dp_bias),
    .dp_last    (dp_last)
  );

  // Single-port memory, registered address, 1-cycle read latency.
  logic [DWIDTH-1:0]  mem [0:(1<<NETSIZE)-1];
  logic [NETSIZE-1:0] mem_addr_q;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= write_data;
    mem_addr_q <= mem_addr;
  end
  assign read_data = mem[mem_addr_q];

  // Reference contents as the host intended them.
  logic [DWIDTH-1:0] ref_mem [0:(1<<NETSIZE)-1];

  typedef struct {
    logic [DWIDTH-1:0] data;
    logic              bias;
    logic              last;
  } beat_t;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic host_write(input logic [NETSIZE-1:0] a, input logic [DWIDTH-1:0] d);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    #1;
    chk("host_ready_idle", 32'(host_ready), 32'd1);
    chk("mem_we_idle", 32'(mem_we), 32'd1);
    ref_mem[a] = d;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  // mode 0: ready always; 1: random ready; 2: 3-cycle stalls on beats 2 and 6.
  task automatic run_stream(input logic [NETSIZE-1:0] base, input logic [NETSIZE-1:0] nin,
                            input logic [NETSIZE-1:0] nout, input int mode, input int abort_after);
    beat_t exp_q[$];
    beat_t b;
    logic [NETSIZE-1:0] a;
    int k, popped, held, first_k, last_k, total_beats;
    bit got_done, aborted;
    a = base;
    for (int n = 0; n < int'(nout); n++) begin
      for (int w = 0; w <= int'(nin); w++) begin
        b.data = ref_mem[a];
        b.bias = (w == int'(nin));
        b.last = (n == int'(nout) - 1) && (w == int'(nin));
        exp_q.push_back(b);
        a = a + NETSIZE'(1);
      end
    end
    total_beats = exp_q.size();
    k = 0; popped = 0; held = 0; first_k = -1; last_k = -1;
    got_done = 1'b0; aborted = 1'b0;

    @(negedge clk);
    cfg_base = base; cfg_in = nin; cfg_out = nout; start = 1'b1;
    while (k < 400) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        start = 1'b0;
        cfg_base = NETSIZE'($urandom); cfg_in = NETSIZE'($urandom); cfg_out = NETSIZE'($urandom);
      end
      if (k == 2 && nout != '0) begin
        start = 1'b1;
        host_we = 1'b1; host_addr = NETSIZE'(5); host_wdata = 16'hDEAD;
        #1;
        chk("busy_run", 32'(busy), 32'd1);
        chk("mem_we_busy", 32'(mem_we), 32'd0);
        chk("host_ready_busy", 32'(host_ready), 32'd0);
      end
      if (k == 3) begin
        start = 1'b0; host_we = 1'b0;
      end
      if (abort_after >= 0 && popped == abort_after && dp_valid) begin
        rst = 1'b1;
        #1;
        chk("rst_dp_valid", 32'(dp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0; host_we = 1'b0;
        #1;
        chk("rst_host_ready", 32'(host_ready), 32'd1);
        aborted = 1'b1;
        break;
      end
      case (mode)
        1: dp_ready = 1'($urandom_range(0, 1));
        2: begin
          if (dp_valid && (popped == 1 || popped == 5) && held < 3) begin
            dp_ready = 1'b0; held++;
          end else begin
            dp_ready = 1'b1;
          end
        end
        default: dp_ready = 1'b1;
      endcase
      if (dp_valid) begin
        if (first_k < 0) first_k = k;
        if (exp_q.size() == 0) begin
          chk("extra_beat", 32'd1, 32'd0);
        end else begin
          chk("dp_data", 32'(dp_data), 32'(exp_q[0].data));
          chk("dp_bias", 32'(dp_bias), 32'(exp_q[0].bias));
          chk("dp_last", 32'(dp_last), 32'(exp_q[0].last));
          if (dp_ready) begin
            void'(exp_q.pop_front());
            popped++; held = 0; last_k = k;
          end
        end
      end
      if (done) begin
        got_done = 1'b1;
        chk("done_time", 32'(k), (nout == '0) ? 32'd1 : 32'(last_k + 1));
        chk("valid_at_done", 32'(dp_valid), 32'd0);
        break;
      end
    end
    if (!aborted) begin
      chk("got_done", 32'(got_done), 32'd1);
      chk("beat_count", 32'(popped), 32'(total_beats));
      chk("first_valid", 32'(first_k), (nout == '0) ? 32'hFFFF_FFFF : 32'd2);
      @(negedge clk);
      chk("done_pulse", 32'(done), 32'd0);
      chk("busy_after", 32'(busy), 32'd0);
      chk("host_ready_after", 32'(host_ready), 32'd1);
      chk("mem5_unchanged", 32'(mem[5]), 32'(ref_mem[5]));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_base = '0; cfg_in = '0; cfg_out = '0;
    host_we = 1'b0; host_addr = '0; host_wdata = '0; dp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy0", 32'(busy), 32'd0);
    chk("rst_done0", 32'(done), 32'd0);
    chk("rst_valid0", 32'(dp_valid), 32'd0);
    chk("rst_bias0", 32'(dp_bias), 32'd0);
    chk("rst_last0", 32'(dp_last), 32'd0);
    chk("rst_mem_we0", 32'(mem_we), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("host_ready_post_rst", 32'(host_ready), 32'd1);

    for (int i = 0; i < 8; i++) host_write(NETSIZE'(i), DWIDTH'(100 + i));
    for (int i = 8; i < 64; i++) host_write(NETSIZE'(i), DWIDTH'($urandom));
    host_write(NETSIZE'(12'hFFE), 16'hA5FE);
    host_write(NETSIZE'(12'hFFF), 16'hA5FF);

    run_stream(NETSIZE'(0), NETSIZE'(3), NETSIZE'(2), 0, -1);
    run_stream(NETSIZE'(0), NETSIZE'(3), NETSIZE'(2), 2, -1);
    run_stream(NETSIZE'(10), NETSIZE'(3), NETSIZE'(0), 0, -1);
    run_stream(NETSIZE'(20), NETSIZE'(0), NETSIZE'(3), 0, -1);
    run_stream(NETSIZE'(12'hFFE), NETSIZE'(2), NETSIZE'(1), 1, -1);
    run_stream(NETSIZE'(0), NETSIZE'(3), NETSIZE'(2), 0, 2);
    run_stream(NETSIZE'(0), NETSIZE'(3), NETSIZE'(2), 0, -1);
    for (int r = 0; r < 8; r++) begin
      run_stream(NETSIZE'($urandom_range(0, 40)), NETSIZE'($urandom_range(0, 3)),
                 NETSIZE'($urandom_range(0, 5)), 1, -1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
